// File: rtl/uart_tx_arbiter.sv
// Three-requester packet arbiter feeding a single UART transmitter.
// Round-robin grant held for a whole packet, revoked if the owner idles too long.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLKIN,
    input  logic        RESET,
    input  logic        clock_enable,
    input  logic [2:0]  req_valid,
    input  logic [23:0] req_data,
    input  logic [2:0]  req_last,
    output logic [2:0]  req_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [2:0]  grant,
    output logic        timeout_err
);

    typedef enum logic {StIdle, StLocked} state_e;

    localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);

    state_e      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  last_q, last_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic        timeout_err_q, timeout_err_d;

    logic [1:0]  cand1, cand2, pick;
    logic [2:0]  owner_oh;
    logic [7:0]  owner_byte;
    logic        locked, owner_valid, owner_last, xfer, timed_out;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Priority order after the last owner p: p+1, p+2, then p itself.
    always_comb begin
        cand1 = next_idx(last_q);
        cand2 = next_idx(cand1);
        if (req_valid[cand1]) begin
            pick = cand1;
        end else if (req_valid[cand2]) begin
            pick = cand2;
        end else begin
            pick = last_q;
        end
    end

    always_comb begin
        owner_oh   = 3'b000;
        owner_byte = 8'h00;
        unique case (owner_q)
            2'd0: begin
                owner_oh   = 3'b001;
                owner_byte = req_data[7:0];
            end
            2'd1: begin
                owner_oh   = 3'b010;
                owner_byte = req_data[15:8];
            end
            2'd2: begin
                owner_oh   = 3'b100;
                owner_byte = req_data[23:16];
            end
            default: begin
                owner_oh   = 3'b000;
                owner_byte = 8'h00;
            end
        endcase
    end

    assign locked      = (state_q == StLocked);
    assign owner_valid = |(req_valid & owner_oh);
    assign owner_last  = |(req_last & owner_oh);
    assign xfer        = locked && owner_valid && tx_ready && clock_enable;
    assign timed_out   = locked && !owner_valid && (idle_cnt_q >= TimeoutVal);

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        idle_cnt_d    = idle_cnt_q;
        timeout_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                idle_cnt_d = 16'd0;
                if (|req_valid) begin
                    owner_d = pick;
                    state_d = StLocked;
                end
            end
            StLocked: begin
                // Only baud ticks with the owner silent count as idle time.
                if (owner_valid) begin
                    idle_cnt_d = 16'd0;
                end else if (clock_enable) begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                end
                if (xfer && owner_last) begin
                    state_d = StIdle;
                    last_d  = owner_q;
                end else if (timed_out) begin
                    state_d       = StIdle;
                    last_d        = owner_q;
                    timeout_err_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            state_q       <= StIdle;
            owner_q       <= 2'd0;
            last_q        <= 2'd2;
            idle_cnt_q    <= 16'd0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            idle_cnt_q    <= idle_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        grant       = locked ? owner_oh : 3'b000;
        tx_valid    = locked && owner_valid;
        tx_data     = locked ? owner_byte : 8'h00;
        req_ready   = (locked && tx_ready && clock_enable) ? owner_oh : 3'b000;
        timeout_err = timeout_err_q;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scenario bench for uart_tx_arbiter: each transfer is popped from an expected-byte queue.
module tb_uart_tx_arbiter;

    logic        CLKIN = 1'b0;
    logic        RESET;
    logic        clock_enable;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_last;
    logic [2:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [2:0]  grant;
    logic        timeout_err;

    typedef struct packed {
        logic [2:0] gnt;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passed = 0;

    uart_tx_arbiter #(.TIMEOUT(4)) dut (
        .CLKIN        (CLKIN),
        .RESET        (RESET),
        .clock_enable (clock_enable),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .grant        (grant),
        .timeout_err  (timeout_err)
    );

    always #5 CLKIN = ~CLKIN;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push(input logic [2:0] g, input logic [7:0] d);
        exp_t e;
        e.gnt  = g;
        e.data = d;
        sb_q.push_back(e);
    endtask

    // Advance one clock; a handshake seen at the falling edge is checked against the queue.
    task automatic cycle();
        exp_t e;
        @(negedge CLKIN);
        if (!RESET && tx_valid === 1'b1 && tx_ready && clock_enable) begin
            checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected: got grant=%b data=%h, required no transfer",
                         grant, tx_data);
            end else begin
                e = sb_q.pop_front();
                if (grant !== e.gnt || tx_data !== e.data || req_ready !== e.gnt) begin
                    $display("FAIL sb_xfer: got grant=%b ready=%b data=%h, required %b/%b/%h",
                             grant, req_ready, tx_data, e.gnt, e.gnt, e.data);
                end else begin
                    passed++;
                end
            end
        end
        @(posedge CLKIN);
        #1;
    endtask

    // Single-byte packets from every requester in mask, drained by handshake.
    task automatic drain(input logic [2:0] mask, input string name);
        logic [2:0] pend;
        logic [2:0] hs;
        pend         = mask;
        tx_ready     = 1'b1;
        clock_enable = 1'b1;
        req_last     = 3'b111;
        for (int c = 0; c < 50 && pend != 3'b000; c++) begin
            req_valid = pend;
            #2;
            hs = req_valid & req_ready;
            cycle();
            pend = pend & ~hs;
        end
        req_valid = 3'b000;
        checks++;
        if (sb_q.size() != 0 || pend != 3'b000) begin
            $display("FAIL %s: got %0d bytes left, required 0", name, sb_q.size());
            sb_q.delete();
        end else begin
            passed++;
        end
    endtask

    task automatic test_reset();
        RESET        = 1'b1;
        req_valid    = 3'b111;
        req_data     = 24'hFFFFFF;
        req_last     = 3'b111;
        tx_ready     = 1'b1;
        clock_enable = 1'b1;
        repeat (3) cycle();
        checks++;
        if (grant !== 3'b000) $display("FAIL rst_hold_grant: got %b required 000", grant);
        else passed++;
        RESET     = 1'b0;
        req_valid = 3'b000;
        #1;
        checks++;
        if (grant !== 3'b000) $display("FAIL rst_grant: got %b required 000", grant);
        else passed++;
        checks++;
        if (tx_valid !== 1'b0) $display("FAIL rst_tx_valid: got %b required 0", tx_valid);
        else passed++;
        checks++;
        if (tx_data !== 8'h00) $display("FAIL rst_tx_data: got %h required 00", tx_data);
        else passed++;
        checks++;
        if (req_ready !== 3'b000) $display("FAIL rst_ready: got %b required 000", req_ready);
        else passed++;
        checks++;
        if (timeout_err !== 1'b0) $display("FAIL rst_tmo: got %b required 0", timeout_err);
        else passed++;
        clock_enable = 1'b0;
        req_data     = 24'h000000;
    endtask

    task automatic test_fair();
        req_data = {8'hC2, 8'hB1, 8'hA0};
        req_last = 3'b111;
        tx_ready = 1'b1;
        push(3'b001, 8'hA0);
        push(3'b010, 8'hB1);
        push(3'b100, 8'hC2);
        push(3'b001, 8'hA0);
        for (int c = 0; c < 100 && sb_q.size() > 0; c++) begin
            clock_enable = (c % 4 == 3);
            req_valid    = 3'b111;
            cycle();
        end
        req_valid    = 3'b000;
        clock_enable = 1'b0;
        checks++;
        if (sb_q.size() != 0) begin
            $display("FAIL fair_drain: got %0d bytes left, required 0", sb_q.size());
            sb_q.delete();
        end else begin
            passed++;
        end
        cycle();
        checks++;
        if (grant !== 3'b000) $display("FAIL fair_release: got %b required 000", grant);
        else passed++;
    endtask

    task automatic test_packet();
        logic [7:0] b1 [3];
        int         i1;
        logic       r0_done;
        logic       hs0, hs1;
        b1[0] = 8'h41;
        b1[1] = 8'h42;
        b1[2] = 8'h43;
        i1      = 0;
        r0_done = 1'b0;
        tx_ready     = 1'b1;
        clock_enable = 1'b1;
        push(3'b010, 8'h41);
        push(3'b010, 8'h42);
        push(3'b010, 8'h43);
        push(3'b001, 8'h10);
        for (int c = 0; c < 40 && sb_q.size() > 0; c++) begin
            req_valid = {1'b0, i1 < 3, !r0_done};
            req_data  = {8'h00, b1[(i1 < 3) ? i1 : 2], 8'h10};
            req_last  = {1'b0, i1 == 2, 1'b1};
            #2;
            hs0 = req_valid[0] && req_ready[0];
            hs1 = req_valid[1] && req_ready[1];
            cycle();
            if (hs1) i1++;
            if (hs0) r0_done = 1'b1;
        end
        req_valid = 3'b000;
        checks++;
        if (sb_q.size() != 0) begin
            $display("FAIL pkt_drain: got %0d bytes left, required 0", sb_q.size());
            sb_q.delete();
        end else begin
            passed++;
        end
        cycle();
        checks++;
        if (grant !== 3'b000) $display("FAIL pkt_release: got %b required 000", grant);
        else passed++;
    endtask

    task automatic test_reset_mid();
        req_valid    = 3'b010;
        req_data     = {8'h00, 8'h31, 8'h00};
        req_last     = 3'b000;
        tx_ready     = 1'b1;
        clock_enable = 1'b1;
        push(3'b010, 8'h31);
        cycle();
        checks++;
        if (grant !== 3'b010) $display("FAIL rmid_lock: got %b required 010", grant);
        else passed++;
        cycle();
        req_data = {8'h00, 8'h32, 8'h00};
        RESET    = 1'b1;
        cycle();
        RESET     = 1'b0;
        req_valid = 3'b011;
        req_data  = {8'h00, 8'h61, 8'h60};
        req_last  = 3'b011;
        #1;
        checks++;
        if (req_ready !== 3'b000) $display("FAIL rmid_ready: got %b required 000", req_ready);
        else passed++;
        checks++;
        if (grant !== 3'b000 || tx_valid !== 1'b0)
            $display("FAIL rmid_idle: got grant=%b valid=%b required 000/0", grant, tx_valid);
        else passed++;
        checks++;
        if (sb_q.size() != 0) begin
            $display("FAIL rmid_first: got %0d bytes left, required 0", sb_q.size());
            sb_q.delete();
        end else begin
            passed++;
        end
        clock_enable = 1'b0;
        cycle();
        checks++;
        if (grant !== 3'b001) $display("FAIL rmid_regrant: got %b required 001", grant);
        else passed++;
        push(3'b001, 8'h60);
        push(3'b010, 8'h61);
        drain(3'b011, "rmid_drain");
    endtask

    task automatic test_timeout();
        logic seen;
        req_valid    = 3'b100;
        req_data     = {8'h77, 8'h00, 8'h00};
        req_last     = 3'b000;
        tx_ready     = 1'b1;
        clock_enable = 1'b1;
        push(3'b100, 8'h77);
        cycle();
        checks++;
        if (grant !== 3'b100) $display("FAIL tmo_lock: got %b required 100", grant);
        else passed++;
        cycle();
        req_valid = 3'b000;
        for (int k = 0; k < 4; k++) begin
            clock_enable = 1'b0;
            cycle();
            checks++;
            if (timeout_err !== 1'b0 || grant !== 3'b100)
                $display("FAIL tmo_early: got err=%b grant=%b required 0/100", timeout_err, grant);
            else passed++;
            clock_enable = 1'b1;
            cycle();
            if (k < 3) begin
                checks++;
                if (timeout_err !== 1'b0 || grant !== 3'b100)
                    $display("FAIL tmo_tick: got err=%b grant=%b required 0/100",
                             timeout_err, grant);
                else passed++;
            end
        end
        clock_enable = 1'b0;
        seen = 1'b0;
        for (int w = 0; w < 4 && !seen; w++) begin
            if (timeout_err === 1'b1) seen = 1'b1;
            else cycle();
        end
        checks++;
        if (!seen) $display("FAIL tmo_pulse: got err=0 required a pulse");
        else passed++;
        checks++;
        if (grant !== 3'b000) $display("FAIL tmo_release: got %b required 000", grant);
        else passed++;
        cycle();
        checks++;
        if (timeout_err !== 1'b0) $display("FAIL tmo_width: got %b required 0", timeout_err);
        else passed++;
        req_data = {8'hA2, 8'h00, 8'hA0};
        push(3'b001, 8'hA0);
        push(3'b100, 8'hA2);
        drain(3'b101, "tmo_next");
    endtask

    task automatic test_stall();
        req_valid    = 3'b010;
        req_data     = {8'h00, 8'h55, 8'h00};
        req_last     = 3'b000;
        tx_ready     = 1'b1;
        clock_enable = 1'b1;
        push(3'b010, 8'h55);
        push(3'b010, 8'h56);
        cycle();
        cycle();
        req_data = {8'h00, 8'h56, 8'h00};
        req_last = 3'b010;
        tx_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            clock_enable = (c % 2 == 0);
            cycle();
            checks++;
            if (grant !== 3'b010 || req_ready !== 3'b000)
                $display("FAIL stall_hold: got grant=%b ready=%b required 010/000",
                         grant, req_ready);
            else passed++;
            checks++;
            if (timeout_err !== 1'b0 || dut.idle_cnt_q !== 16'd0)
                $display("FAIL stall_timer: got err=%b timer=%0d required 0/0",
                         timeout_err, dut.idle_cnt_q);
            else passed++;
        end
        checks++;
        if (sb_q.size() != 1) $display("FAIL stall_count: got %0d left, required 1", sb_q.size());
        else passed++;
        tx_ready     = 1'b1;
        clock_enable = 1'b1;
        cycle();
        req_valid = 3'b000;
        checks++;
        if (grant !== 3'b000 || sb_q.size() != 0) begin
            $display("FAIL stall_end: got grant=%b left=%0d required 000/0", grant, sb_q.size());
            sb_q.delete();
        end else begin
            passed++;
        end
    endtask

    task automatic test_coincide();
        req_valid    = 3'b001;
        req_data     = {8'h00, 8'h00, 8'h90};
        req_last     = 3'b000;
        tx_ready     = 1'b1;
        clock_enable = 1'b1;
        push(3'b001, 8'h90);
        cycle();
        cycle();
        req_valid = 3'b000;
        repeat (4) cycle();
        req_valid = 3'b001;
        req_data  = {8'h00, 8'h00, 8'h91};
        req_last  = 3'b001;
        push(3'b001, 8'h91);
        cycle();
        req_valid = 3'b000;
        checks++;
        if (sb_q.size() != 0) begin
            $display("FAIL coin_xfer: got %0d bytes left, required 0", sb_q.size());
            sb_q.delete();
        end else begin
            passed++;
        end
        checks++;
        if (timeout_err !== 1'b0 || grant !== 3'b000)
            $display("FAIL coin_err: got err=%b grant=%b required 0/000", timeout_err, grant);
        else passed++;
        cycle();
        checks++;
        if (timeout_err !== 1'b0) $display("FAIL coin_err2: got %b required 0", timeout_err);
        else passed++;
    endtask

    initial begin
        RESET        = 1'b1;
        clock_enable = 1'b0;
        req_valid    = 3'b000;
        req_data     = 24'h000000;
        req_last     = 3'b000;
        tx_ready     = 1'b0;
        #1;
        test_reset();
        test_fair();
        test_packet();
        test_reset_mid();
        test_timeout();
        test_stall();
        test_coincide();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 255, number of baud ticks an idle locked requester may hold the grant; legal range 1..65535.
REQ-002 Port: CLKIN  input  1  system clock; every register is clocked on its rising edge.
REQ-003 Port: RESET  input  1  synchronous, active-high reset.
REQ-004 Port: clock_enable  input  1  baud tick that qualifies transmitter handshakes.
REQ-005 Port: req_valid  input  3  per-requester byte valid; bit i belongs to requester i.
REQ-006 Port: req_data  input  24  per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 Port: req_last  input  3  per-requester end-of-packet marker for the current byte.
REQ-008 Port: req_ready  output  3  per-requester transfer acknowledge.
REQ-009 Port: tx_data  output  8  byte to the UART transmitter.
REQ-010 Port: tx_valid  output  1  byte valid to the transmitter.
REQ-011 Port: tx_ready  input  1  transmitter can accept a byte.
REQ-012 Port: grant  output  3  one-hot current owner; all zero when not locked.
REQ-013 Port: timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-014 The arbiter SHALL have two states: IDLE and LOCKED, with a registered 2-bit owner index g and a 2-bit last-owner pointer p.
REQ-015 In IDLE, grant, tx_valid and req_ready SHALL be 0, and no transfer SHALL occur.
REQ-016 In IDLE with any req_valid bit set, the arbiter SHALL select the first valid requester in the order p+1, p+2, p (mod 3), register it as g, and enter LOCKED on the next edge.
REQ-017 Arbitration SHALL not depend on clock_enable, so a grant is issued one CLKIN cycle after a request appears.
REQ-018 In LOCKED, grant SHALL equal one-hot(g), and tx_data SHALL equal req_data byte g combinationally.
REQ-019 In LOCKED, tx_valid SHALL equal req_valid[g].
REQ-020 In LOCKED, req_ready[g] SHALL equal tx_ready AND clock_enable; all other req_ready bits SHALL be 0.
REQ-021 A transfer SHALL occur on a cycle where LOCKED, req_valid[g], tx_ready and clock_enable are all 1; exactly one byte moves per transfer.
REQ-022 A transfer with req_last[g]=1 SHALL return the state to IDLE and set p=g on the same edge.
REQ-023 A single-byte packet (last=1 on the first byte) SHALL be legal.
REQ-024 A transfer with req_last[g]=0 SHALL keep the grant, so packets are never interleaved.
REQ-025 Requests from non-owners SHALL be ignored while LOCKED, whatever their valid or last values.
REQ-026 A 16-bit idle timer SHALL clear on entry to LOCKED and on every cycle where req_valid[g]=1.
REQ-027 The idle timer SHALL increment on each clock_enable cycle in LOCKED with req_valid[g]=0.
REQ-028 When the idle timer reaches TIMEOUT while LOCKED and req_valid[g]=0, the arbiter SHALL enter IDLE, set p=g, and drive timeout_err=1 for exactly one cycle.
REQ-029 If a transfer and the timeout condition coincide, the transfer SHALL take precedence and timeout_err SHALL stay 0.
REQ-030 Arbitration SHALL be fair: with all three requesters continuously valid, packets SHALL be granted in the order 0,1,2,0,...
REQ-031 tx_ready falling mid-packet SHALL only stall transfers; it SHALL neither release the grant nor advance the idle timer.

Reset
REQ-032 With RESET=1 at a rising edge, the arbiter SHALL set state=IDLE, g=0, p=2 (so requester 0 has first priority), idle timer=0 and timeout_err=0.
REQ-033 After reset, grant, tx_valid, tx_data and req_ready SHALL read 0.
REQ-034 RESET SHALL take precedence over every other event, including a transfer in the same cycle.
REQ-035 A reset during LOCKED SHALL abandon the packet without further transfers.

Verification
REQ-036 Scenario: reset, then req_valid=3'b111 held with req_last=1 on every byte, tx_ready=1, clock_enable every 4th cycle -> grants and tx_data sequence 0,1,2,0 with one byte per tick.
REQ-037 Scenario: requester 1 sends a 3-byte packet 0x41,0x42,0x43 (last on 0x43) while requester 0 is valid -> bytes 0x41,0x42,0x43 leave contiguously, then requester 0 is granted.
REQ-038 Scenario: TIMEOUT=4, requester 2 is granted and its first byte transfers with last=0, then req_valid[2] drops -> after 4 ticks a timeout_err pulse occurs, grant=0, and the next grant goes to requester 0.
REQ-039 Scenario: tx_ready=0 for 20 cycles mid-packet, including clock_enable cycles -> no transfer, grant held, timer stays 0, no timeout_err.
REQ-040 Scenario: RESET asserted on the cycle of a transfer mid-packet from requester 1 -> req_ready=0 next cycle, state IDLE, and requester 0 wins the next simultaneous 0/1 request.
REQ-041 Scenario: the transfer and the TIMEOUT-th idle tick coincide -> the byte transfers and timeout_err stays 0.
